// File: rtl/siphash_pkg.sv
// siphash_pkg
// Shared definitions for the SipHash message sequencer slice: sequencer FSM
// state encoding and the fixed widths of the 64-bit SipHash core interface.
// No ports (package).
package siphash_pkg;

    localparam int SIPHASH_WORD_BYTES = 8;
    localparam int SIPHASH_LEN_BITS   = 8;
    localparam int DIGEST_W           = 64;
    localparam int WORD_W             = 8 * SIPHASH_WORD_BYTES;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INIT      = 3'd1,
        ST_COLLECT   = 3'd2,
        ST_COMP      = 3'd3,
        ST_COMP_WAIT = 3'd4,
        ST_FIN       = 3'd5,
        ST_FIN_WAIT  = 3'd6
    } seq_state_e;

endpackage

// File: rtl/siphash_byte_packer.sv
// siphash_byte_packer
// Packs message bytes little-endian into a 64-bit SipHash message word,
// counts the total message length mod 256 and forms the final/padding words.
// Ports:
//   clk, reset_n  clock, async active-low reset
//   clear         start of a new message: clear word, byte index and length
//   accept        s_data is taken this cycle
//   load_pad      replace word with the length-only padding block
//   clear_word    current word consumed: clear word and byte index
//   s_data        message byte
//   s_last        accepted byte is the final byte of the message
//   word          current message word (drives core_mi)
//   last_slot     next accepted byte fills the top byte of the word
module siphash_byte_packer
    import siphash_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              accept,
    input  logic              load_pad,
    input  logic              clear_word,
    input  logic [7:0]        s_data,
    input  logic              s_last,
    output logic [WORD_W-1:0] word,
    output logic              last_slot
);

    localparam int IDX_W = $clog2(SIPHASH_WORD_BYTES);

    logic [IDX_W-1:0]            byte_idx, byte_idx_nxt;
    logic [SIPHASH_LEN_BITS-1:0] len_ctr, len_ctr_nxt, len_inc;
    logic [WORD_W-1:0]           word_nxt;

    assign len_inc   = len_ctr + 1'b1;
    assign last_slot = (byte_idx == IDX_W'(SIPHASH_WORD_BYTES - 1));

    // A short final word carries the updated length in its top byte; the
    // zero-filled bytes in between are already zero from the last clear.
    always_comb begin
        word_nxt     = word;
        byte_idx_nxt = byte_idx;
        len_ctr_nxt  = len_ctr;
        if (clear) begin
            word_nxt     = '0;
            byte_idx_nxt = '0;
            len_ctr_nxt  = '0;
        end else if (accept) begin
            word_nxt[{byte_idx, 3'b000} +: 8] = s_data;
            byte_idx_nxt = byte_idx + 1'b1;
            len_ctr_nxt  = len_inc;
            if (s_last && !last_slot) begin
                word_nxt[WORD_W-1 -: SIPHASH_LEN_BITS] = len_inc;
            end
        end else if (load_pad) begin
            word_nxt = {len_ctr, {(WORD_W - SIPHASH_LEN_BITS){1'b0}}};
        end else if (clear_word) begin
            word_nxt     = '0;
            byte_idx_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word     <= '0;
            byte_idx <= '0;
            len_ctr  <= '0;
        end else begin
            word     <= word_nxt;
            byte_idx <= byte_idx_nxt;
            len_ctr  <= len_ctr_nxt;
        end
    end

endmodule

// File: rtl/siphash_msg_sequencer.sv
// siphash_msg_sequencer
// Initiator-side front end for siphash_core: takes a byte stream, packs and
// pads it into 64-bit words, sequences initalize/compress/finalize pulses and
// folds the 128-bit core result into the 64-bit SipHash digest.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   start, empty                 begin a message (empty=1: zero length)
//   s_data/s_valid/s_last/s_ready byte stream
//   core_initalize/compress/finalize, core_mi   commands to the core
//   core_ready, core_word, core_word_valid      status from the core
//   digest, digest_valid, busy   result and status
module siphash_msg_sequencer
    import siphash_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                empty,
    input  logic [7:0]          s_data,
    input  logic                s_valid,
    input  logic                s_last,
    output logic                s_ready,
    output logic                core_initalize,
    output logic                core_compress,
    output logic                core_finalize,
    output logic [WORD_W-1:0]   core_mi,
    input  logic                core_ready,
    input  logic [127:0]        core_word,
    input  logic                core_word_valid,
    output logic [DIGEST_W-1:0] digest,
    output logic                digest_valid,
    output logic                busy
);

    seq_state_e state, state_nxt;

    logic empty_q;
    logic last_block, last_nxt;
    logic pad_pending, pad_nxt;
    logic wait_first;
    logic busy_nxt, dv_nxt, digest_ld;
    logic pk_clear, pk_accept, pk_load_pad, pk_clear_word, pk_last_slot;

    siphash_byte_packer u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (pk_clear),
        .accept     (pk_accept),
        .load_pad   (pk_load_pad),
        .clear_word (pk_clear_word),
        .s_data     (s_data),
        .s_last     (s_last),
        .word       (core_mi),
        .last_slot  (pk_last_slot)
    );

    // The core's ready/valid lag one cycle behind a command pulse, so the
    // first cycle in each WAIT state is a guard cycle that ignores them.
    always_comb begin
        state_nxt      = state;
        last_nxt       = last_block;
        pad_nxt        = pad_pending;
        busy_nxt       = busy;
        dv_nxt         = digest_valid;
        digest_ld      = 1'b0;
        s_ready        = 1'b0;
        core_initalize = 1'b0;
        core_compress  = 1'b0;
        core_finalize  = 1'b0;
        pk_clear       = 1'b0;
        pk_accept      = 1'b0;
        pk_load_pad    = 1'b0;
        pk_clear_word  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    pk_clear  = 1'b1;
                    dv_nxt    = 1'b0;
                    busy_nxt  = 1'b1;
                    state_nxt = ST_INIT;
                end
            end
            ST_INIT: begin
                core_initalize = 1'b1;
                last_nxt       = empty_q;
                pad_nxt        = 1'b0;
                state_nxt      = empty_q ? ST_COMP : ST_COLLECT;
            end
            ST_COLLECT: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    pk_accept = 1'b1;
                    if (pk_last_slot) begin
                        // A message ending on a word boundary still needs the
                        // length-only block afterwards.
                        last_nxt  = 1'b0;
                        pad_nxt   = s_last;
                        state_nxt = ST_COMP;
                    end else if (s_last) begin
                        last_nxt  = 1'b1;
                        state_nxt = ST_COMP;
                    end
                end
            end
            ST_COMP: begin
                core_compress = 1'b1;
                state_nxt     = ST_COMP_WAIT;
            end
            ST_COMP_WAIT: begin
                if (!wait_first && core_ready) begin
                    if (pad_pending) begin
                        pk_load_pad = 1'b1;
                        pad_nxt     = 1'b0;
                        last_nxt    = 1'b1;
                        state_nxt   = ST_COMP;
                    end else if (last_block) begin
                        state_nxt = ST_FIN;
                    end else begin
                        pk_clear_word = 1'b1;
                        state_nxt     = ST_COLLECT;
                    end
                end
            end
            ST_FIN: begin
                core_finalize = 1'b1;
                state_nxt     = ST_FIN_WAIT;
            end
            ST_FIN_WAIT: begin
                if (!wait_first && core_word_valid) begin
                    digest_ld = 1'b1;
                    dv_nxt    = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            empty_q      <= 1'b0;
            last_block   <= 1'b0;
            pad_pending  <= 1'b0;
            wait_first   <= 1'b0;
            busy         <= 1'b0;
            digest_valid <= 1'b0;
            digest       <= '0;
        end else begin
            state        <= state_nxt;
            last_block   <= last_nxt;
            pad_pending  <= pad_nxt;
            busy         <= busy_nxt;
            digest_valid <= dv_nxt;
            wait_first   <= (state == ST_COMP) || (state == ST_FIN);
            if (state == ST_IDLE && start) begin
                empty_q <= empty;
            end
            if (digest_ld) begin
                digest <= core_word[127:64] ^ core_word[63:0];
            end
        end
    end

endmodule
